reg_bank_wr_arbiter: RTL and testbench



---
 rtl/reg_bank_wr_arbiter_pkg.sv | 8 +
 rtl/reg_bank_wr_arbiter_entry.sv | 14 +
 rtl/reg_bank_wr_arbiter.sv | 78 +++++++
 tb/tb_reg_bank_wr_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_wr_arbiter_pkg.sv
// reg_bank_wr_arbiter_pkg: shared sizes and encodings for the arbitrated register bank
package reg_bank_wr_arbiter_pkg;
    localparam int DEF_DW   = 32;
    localparam int DEF_NREG = 8;
    localparam int DEF_AW   = 3;
    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;
    typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_t;
endpackage

// File: rtl/reg_bank_wr_arbiter_entry.sv
// reg_entry_we: one storage word with write enable and synchronous reset
module reg_entry_we #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (we) q <= d;
endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// reg_bank_wr_arbiter: 8x32 register bank, round-robin shared write port, clear sweep
module reg_bank_wr_arbiter
    import reg_bank_wr_arbiter_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    output logic          ack_b,
    input  logic          clr_start,
    output logic          busy,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    state_t        state;
    rr_t           rr;
    logic [AW-1:0] cnt;
    logic [DW-1:0] q [NREG];
    logic          clearing, va, vb, gnt_a, gnt_b;
    logic [DW-1:0] wdata;

    // a requester whose ack is high this cycle is already served; mask it
    always_comb begin
        clearing = state == S_CLEAR;
        va       = req_a & ~ack_a;
        vb       = req_b & ~ack_b;
        gnt_a    = ~clearing & ~clr_start & va & (~vb | rr == RR_A);
        gnt_b    = ~clearing & ~clr_start & vb & (~va | rr == RR_B);
        wdata    = clearing ? '0 : gnt_a ? data_a : data_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            rr    <= RR_A;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
        end else begin
            ack_a <= gnt_a;
            ack_b <= gnt_b;
            if (gnt_a | gnt_b) rr <= gnt_a ? RR_B : RR_A;
            if (clearing) begin
                cnt <= cnt + 1'b1;
                if (cnt == AW'(NREG - 1)) state <= S_IDLE;
            end else if (clr_start) begin
                state <= S_CLEAR;
                cnt   <= '0;
            end
        end
    end

    assign busy = clearing;

    for (genvar i = 0; i < NREG; i++) begin : g_ent
        logic we;
        assign we = clearing ? cnt == AW'(i)
                             : (gnt_a && addr_a == AW'(i)) || (gnt_b && addr_b == AW'(i));
        reg_entry_we #(.DW(DW)) u_ent (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .d     (wdata),
            .q     (q[i])
        );
    end

    assign rd_data = q[rd_addr];
endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// tb_reg_bank_wr_arbiter: directed plus random checks against a bank-level reference model
`timescale 1ns/100ps
module tb_reg_bank_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, clr_start = 1'b0;
    logic [2:0]  addr_a = '0, addr_b = '0, rd_addr = '0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        ack_a, ack_b, busy;
    logic [31:0] rd_data;

    int checks = 0, errors = 0;
    logic [31:0] m_mem [8];
    int          m_left = 0;
    bit          m_rr = 1'b0, m_ack_a = 1'b0, m_ack_b = 1'b0;

    always #10 clk = ~clk;

    reg_bank_wr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .addr_a    (addr_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .clr_start (clr_start),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // the model advances one cycle from the current inputs, then DUT outputs are compared after the edge
    task automatic step();
        bit va, vb, ga, gb;
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_left = 0; m_rr = 1'b0; m_ack_a = 1'b0; m_ack_b = 1'b0;
        end else if (m_left > 0) begin
            m_mem[8 - m_left] = '0;
            m_left--;
            m_ack_a = 1'b0; m_ack_b = 1'b0;
        end else if (clr_start) begin
            m_left = 8;
            m_ack_a = 1'b0; m_ack_b = 1'b0;
        end else begin
            va = req_a && !m_ack_a;
            vb = req_b && !m_ack_b;
            ga = va && (!vb || !m_rr);
            gb = vb && !ga;
            if (ga) m_mem[addr_a] = data_a;
            if (gb) m_mem[addr_b] = data_b;
            if (ga || gb) m_rr = ga;
            m_ack_a = ga; m_ack_b = gb;
        end
        @(posedge clk); #1;
        chk("ack_a", 32'(ack_a), 32'(m_ack_a));
        chk("ack_b", 32'(ack_b), 32'(m_ack_b));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("one_ack", 32'(ack_a & ack_b), 32'd0);
        chk("rd_data", rd_data, m_mem[rd_addr]);
    endtask

    task automatic read_all(input logic [31:0] exp);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("read_all[%0d]", i), rd_data, exp);
        end
    endtask

    initial begin
        // reset state
        step(); step();
        reset = 1'b0;
        read_all(32'h0);

        // single requester A
        req_a = 1'b1; addr_a = 3'd3; data_a = 32'hDEADBEEF;
        step();
        chk("a_only_ack", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        step();
        chk("a_only_pulse", 32'(ack_a), 32'd0);
        chk("a_only_no_b", 32'(ack_b), 32'd0);
        rd_addr = 3'd3; #1;
        chk("a_only_data", rd_data, 32'hDEADBEEF);

        // both held: alternation starting from A after reset
        reset = 1'b1; step(); reset = 1'b0;
        req_a = 1'b1; addr_a = 3'd1; data_a = 32'h11;
        req_b = 1'b1; addr_b = 3'd2; data_b = 32'h22;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("alt_a%0d", k), 32'(ack_a), 32'(k % 2 == 0));
            chk($sformatf("alt_b%0d", k), 32'(ack_b), 32'(k % 2 == 1));
            if (ack_a) data_a = data_a + 32'h100;
            if (ack_b) data_b = data_b + 32'h100;
        end
        req_a = 1'b0; req_b = 1'b0;
        step();

        // prefill, then sweep with B waiting
        for (int i = 0; i < 8; i++) begin
            req_a = 1'b1; addr_a = 3'(i); data_a = 32'hFFFFFFFF;
            step();
            req_a = 1'b0;
            step();
        end
        read_all(32'hFFFFFFFF);
        begin
            int busy_n;
            bit got_b;
            clr_start = 1'b1; req_b = 1'b1; addr_b = 3'd5; data_b = 32'h55;
            step();
            clr_start = 1'b0;
            busy_n = int'(busy);
            got_b = ack_b;
            for (int t = 0; t < 20 && busy; t++) begin
                step();
                busy_n += int'(busy);
                got_b |= ack_b;
            end
            chk("sweep_len", 32'(busy_n), 32'd8);
            chk("sweep_no_b", 32'(got_b), 32'd0);
        end
        read_all(32'h0);
        step();
        chk("b_after_sweep", 32'(ack_b), 32'd1);
        req_b = 1'b0;
        rd_addr = 3'd5; #1;
        chk("b_after_sweep_data", rd_data, 32'h55);

        // clear wins over a simultaneous request
        req_a = 1'b1; addr_a = 3'd6; data_a = 32'hA5A5A5A5; clr_start = 1'b1;
        step();
        chk("clr_wins_ack", 32'(ack_a), 32'd0);
        chk("clr_wins_busy", 32'(busy), 32'd1);
        clr_start = 1'b0;
        for (int t = 0; t < 20 && busy; t++) step();
        step();
        chk("a_after_clr", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        rd_addr = 3'd6; #1;
        chk("a_after_clr_data", rd_data, 32'hA5A5A5A5);

        // reset during a sweep
        req_a = 1'b1; addr_a = 3'd7; data_a = 32'h77;
        step();
        req_a = 1'b0; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        read_all(32'h0);
        req_a = 1'b1; addr_a = 3'd0; data_a = 32'h12345678;
        step();
        chk("post_rst_ack", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        step();
        rd_addr = 3'd0; #1;
        chk("post_rst_data", rd_data, 32'h12345678);

        // random traffic obeying the handshake
        for (int n = 0; n < 400; n++) begin
            if (!req_a || ack_a) begin
                req_a = ($urandom % 3) != 0; addr_a = 3'($urandom); data_a = $urandom;
            end
            if (!req_b || ack_b) begin
                req_b = ($urandom % 3) != 0; addr_b = 3'($urandom); data_b = $urandom;
            end
            clr_start = ($urandom % 25) == 0;
            reset = ($urandom % 150) == 0;
            rd_addr = 3'($urandom);
            step();
        end
        reset = 1'b0; clr_start = 1'b0; req_a = 1'b0; req_b = 1'b0;
        for (int t = 0; t < 10; t++) step();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("final[%0d]", i), rd_data, m_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
